// File: rtl/common.sv
// common: shared operand width, LSU access sizes and controller states
package common;

    localparam int OPERAND_WIDTH = 32;

    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND,
        RESP
    } lsu_state_e;

    // stores only allow the signed encodings; loads allow all five
    function automatic logic size_legal(input logic we, input logic [2:0] size);
        return we ? (size inside {SZ_B, SZ_H, SZ_W})
                  : (size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU});
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: request/response and data-memory signals of the load/store controller
interface lsu_mem_ctrl_if #(parameter int ADDR_WIDTH = 8);

    logic                             req_valid;
    logic                             req_ready;
    logic                             req_we;
    logic [2:0]                       req_size;
    logic [common::OPERAND_WIDTH-1:0] req_addr;
    logic [common::OPERAND_WIDTH-1:0] req_wdata;
    logic                             resp_valid;
    logic                             resp_err;
    logic [31:0]                      resp_rdata;
    logic                             mem_en;
    logic                             mem_we;
    logic [ADDR_WIDTH-1:0]            mem_addr;
    logic [3:0]                       mem_be;
    logic [31:0]                      mem_wdata;
    logic [31:0]                      mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               mem_en, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane placement for stores and extraction/extension for loads
module lsu_align
    import common::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic        split,
    output logic [7:0]  be,
    output logic [63:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic        is_b;
    logic        is_h;
    logic [2:0]  nbytes;
    logic [3:0]  mask;
    logic [63:0] rdata_cat;
    logic [31:0] rdata_sh;

    // a split load sees the first word in word0 and the second in word1; otherwise word1 holds the only word
    always_comb begin
        is_b      = size inside {SZ_B, SZ_BU};
        is_h      = size inside {SZ_H, SZ_HU};
        nbytes    = is_b ? 3'd1 : is_h ? 3'd2 : 3'd4;
        mask      = is_b ? 4'b0001 : is_h ? 4'b0011 : 4'b1111;
        split     = ({1'b0, off} + nbytes) > 3'd4;
        be        = {4'b0000, mask} << off;
        wdata_sh  = {32'b0, wdata} << {off, 3'b000};
        rdata_cat = split ? {word1, word0} : {32'b0, word1};
        rdata_sh  = 32'(rdata_cat >> {off, 3'b000});
        rdata_ext = is_b ? {{24{~size[2] & rdata_sh[7]}}, rdata_sh[7:0]}
                  : is_h ? {{16{~size[2] & rdata_sh[15]}}, rdata_sh[15:0]}
                  : rdata_sh;
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: one-at-a-time load/store sequencer with misaligned-access splitting
module lsu_mem_ctrl
    import common::*;
#(
    parameter int ADDR_WIDTH = 8
)
(
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);

    localparam int                    AW      = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] WORD_ONE = 1;

    lsu_state_e    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [2:0]    size_q, size_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   word0_q, word0_d;
    logic          split;
    logic [7:0]    be;
    logic [63:0]   wdata_sh;
    logic [31:0]   rdata_ext;

    lsu_align u_align (
        .size      (size_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .word0     (word0_q),
        .word1     (bus.mem_rdata),
        .split     (split),
        .be        (be),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    // state and captured request; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            word0_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            word0_q <= word0_d;
        end
    end

    // sequencing and outputs; memory strobes exist only in FIRST and SECOND
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        size_d         = size_q;
        we_d           = we_q;
        err_d          = err_q;
        wdata_d        = wdata_q;
        word0_d        = word0_q;
        bus.req_ready  = state_q == IDLE;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = '0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_be     = '0;
        bus.mem_wdata  = '0;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                addr_d  = bus.req_addr[AW-1:0];
                size_d  = bus.req_size;
                we_d    = bus.req_we;
                wdata_d = bus.req_wdata;
                err_d   = !size_legal(bus.req_we, bus.req_size);
                state_d = err_d ? RESP : FIRST;
            end
            FIRST: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q[AW-1:2];
                bus.mem_be    = be[3:0];
                bus.mem_wdata = wdata_sh[31:0];
                state_d       = split ? SECOND : RESP;
            end
            SECOND: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = we_q;
                bus.mem_addr  = addr_q[AW-1:2] + WORD_ONE;
                bus.mem_be    = be[7:4];
                bus.mem_wdata = wdata_sh[63:32];
                word0_d       = bus.mem_rdata;
                state_d       = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_q;
                bus.resp_rdata = (err_q || we_q) ? '0 : rdata_ext;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller between the MEM pipeline stage and the single-port, word-organised data memory. It accepts one load or store request at a time and generates the byte enables and shifted write data. A misaligned access is split into two word accesses. Load data is reassembled and sign/zero-extended, and the requester receives a one-cycle completion pulse. It replaces direct stage-to-memory wiring, so the pipeline stalls on `req_ready`.

## Interface
- `ADDR_WIDTH`, default 8: word-address width of the data memory (256 words).
- `clk  in  1  rising-edge clock`
- `rst_n  in  1  reset, asynchronous, active-low`
- `req_valid  in  1  request present; held stable until accepted`
- `req_ready  out  1  high only in IDLE; accept = req_valid & req_ready`
- `req_we  in  1  1 = store, 0 = load`
- `req_size  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores)`
- `req_addr  in  OPERAND_WIDTH  byte address (ALU result)`
- `req_wdata  in  OPERAND_WIDTH  store data, right-justified`
- `resp_valid  out  1  one-cycle completion pulse, no backpressure`
- `resp_err  out  1  qualifies resp_valid: illegal size, no memory access made`
- `resp_rdata  out  32  extended load data; 0 for stores and errors`
- `mem_en  out  1  memory access strobe`
- `mem_we  out  1  write strobe`
- `mem_addr  out  ADDR_WIDTH  word address`
- `mem_be  out  4  byte enables; bit i = byte lane i`
- `mem_wdata  out  32  lane-aligned write data`
- `mem_rdata  in  32  read data, valid the cycle after mem_en`

## Operation
- **FSM states:** IDLE, FIRST, SECOND, RESP.
- **IDLE → FIRST:** on accept with a legal size. Address, size, we and wdata are registered.
- **IDLE → RESP:** on accept with an illegal size. Illegal loads are 011, 110, 111. Illegal stores are any size with bit2 set or 011. The RESP cycle sets resp_err=1.
- **FIRST → SECOND:** when the access is split, otherwise FIRST → RESP. SECOND → RESP. RESP → IDLE unconditionally.
- **Offset and byte count:** off = addr[1:0]; nbytes = 1/2/4. split = (off + nbytes > 4).
- **FIRST:** mem_addr = addr[ADDR_WIDTH+1:2]; mem_be = (mask << off)[3:0].
- **SECOND:** mem_addr = that word + 1, wrapping modulo 2^ADDR_WIDTH; mem_be = (mask << off)[7:4].
- **Write data:** form the 64-bit value {32'b0, wdata} << 8·off. mem_wdata takes bits [31:0] in FIRST and [63:32] in SECOND. mem_we = req_we in both.
- **Load reassembly:** capture the word0 rdata in SECOND. In RESP, form {word1, word0} >> 8·off. For a non-split load, use {32'b0, mem_rdata}.
- **Load extension:** take nbytes. Sign-extend for B and H; zero-extend for BU, HU and W.
- **Byte enables:** lanes outside the access stay unwritten, so no read-modify-write is needed.
- **Address bits:** req_addr bits above ADDR_WIDTH+1 are ignored.
- **Request while busy:** req_valid is ignored while not in IDLE. A request arriving in the RESP cycle is accepted the following IDLE cycle.

## Timing
- **Reset values:** all outputs 0 except req_ready = 1. State = IDLE.
- **Reset mid-access:** return to IDLE immediately, drop mem_en/mem_we, and produce no resp_valid. A half-completed split store may have written word0 only; this is acceptable.
- **Latency:** accept in cycle N. Aligned access: mem_en in N+1, resp_valid in N+2. Split access: mem_en in N+1 and N+2, resp_valid in N+3. Error: resp_valid in N+1.
- **Memory outputs:** mem_* are driven only in FIRST and SECOND, and are 0 in all other states.
- **Throughput:** next accept no earlier than resp_valid + 1 (or in the N+2 cycle for an error).

## Structure
- **Package `common`:** add an lsu_size_e enum (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and an lsu_state_e enum. OPERAND_WIDTH already lives there.
- **Sub-module `lsu_align`:** purely combinational. It computes mask, split, byte enables, the shifted 64-bit write data, and the extracted/extended load result.
- **Top level:** holds the FSM and the capture registers.

## Test plan
- **Aligned SW then LW:** SW addr 0x10, data 0xDEADBEEF → one access, word 4, be 1111; LW 0x10 → resp_rdata 0xDEADBEEF at N+2.
- **Byte stores and loads:** SB 0x80 at 0x21, then LB 0x21 → be 0010, wdata 0x00008000, rdata 0xFFFFFF80. LBU 0x21 → 0x00000080.
- **Misaligned SH at 0x13, data 0xBEEF:** FIRST word 4 be 1000 lane3 = 0xEF; SECOND word 5 be 0001 lane0 = 0xBE. LHU 0x13 → 0x0000BEEF at N+3.
- **Wrap-around:** LW at byte 0x3FE (word 255, off 2) → second access to word 0, result assembled correctly.
- **Illegal size:** load size 011 → no mem_en, resp_valid & resp_err at N+1, rdata 0.
- **Reset during SECOND of a split store:** rst_n low → outputs at reset values asynchronously, no resp_valid; the next request executes normally.
